// File: rtl/frame_canvas.sv
// frame_canvas: double-buffered pixel-code canvas; CLEAR 1 row/cycle, RECT 1 px/cycle, COMMIT copies back->front in one edge.
// cmd_ready is low while a command runs; defining SWAP_ON_VSYNC_EN makes COMMIT wait for a vsync falling edge before the copy.
module frame_canvas #(
  parameter int PX_WIDTH  = 40,
  parameter int PX_HEIGHT = 30,
  parameter int XW        = 6,
  parameter int YW        = 5
) (
  input  logic                            dclk,
  input  logic                            clr_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [1:0]                      cmd_op,
  input  logic [XW-1:0]                   cmd_x,
  input  logic [YW-1:0]                   cmd_y,
  input  logic [XW-1:0]                   cmd_w,
  input  logic [YW-1:0]                   cmd_h,
  input  logic [2:0]                      cmd_color,
  input  logic                            vsync,
  output logic                            busy,
  output logic                            frame_done,
  output logic [PX_WIDTH*PX_HEIGHT*3:0]   pixel
);
  localparam int NB   = PX_WIDTH * PX_HEIGHT * 3;
  localparam int BW   = $clog2(NB);
  localparam int ROWB = PX_WIDTH * 3;

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PAINT, S_WAIT_SYNC, S_COPY} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x0_q, x0_d, cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
  logic [XW:0]   x1_q, x1_d;
  logic [YW:0]   y1_q, y1_d;
  logic [2:0]    color_q, color_d;
  logic          paint_en_q, paint_en_d;
  logic [NB-1:0] back_q, front_q;
  logic          frame_done_q;
  logic          vsync_fall;
  logic          wr_pix, wr_row, do_copy;

  logic [XW:0]   x_sum, x_end;
  logic [YW:0]   y_sum, y_end;
  logic          rect_empty;
  logic [BW-1:0] row_base, pix_base;

`ifdef SWAP_ON_VSYNC_EN
  localparam bit SWAP_SYNC = 1'b1;
  logic vsync_d_q;
  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) vsync_d_q <= 1'b1;
    else        vsync_d_q <= vsync;
  end
  assign vsync_fall = vsync_d_q & ~vsync;
`else
  localparam bit SWAP_SYNC = 1'b0;
  logic unused_vsync;
  assign unused_vsync = vsync;
  assign vsync_fall   = 1'b0;
`endif

  // Sums are one bit wider than the fields so x+w / y+h cannot wrap before clipping.
  assign x_sum      = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum      = {1'b0, cmd_y} + {1'b0, cmd_h};
  assign x_end      = (x_sum > (XW+1)'(PX_WIDTH))  ? (XW+1)'(PX_WIDTH)  : x_sum;
  assign y_end      = (y_sum > (YW+1)'(PX_HEIGHT)) ? (YW+1)'(PX_HEIGHT) : y_sum;
  assign rect_empty = (cmd_x >= XW'(PX_WIDTH)) || (cmd_y >= YW'(PX_HEIGHT)) ||
                      (cmd_w == '0) || (cmd_h == '0);

  assign row_base = BW'(cy_q) * BW'(ROWB);
  assign pix_base = row_base + BW'(cx_q) * BW'(3);

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    color_d    = color_q;
    paint_en_d = paint_en_q;
    wr_pix     = 1'b0;
    wr_row     = 1'b0;
    do_copy    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          color_d = cmd_color;
          case (cmd_op)
            2'd0: begin
              state_d = S_CLEAR;
              cy_d    = '0;
            end
            2'd1: begin
              state_d    = S_PAINT;
              paint_en_d = ~rect_empty;
              x0_d       = cmd_x;
              cx_d       = cmd_x;
              cy_d       = cmd_y;
              x1_d       = x_end;
              y1_d       = y_end;
            end
            2'd2:    state_d = SWAP_SYNC ? S_WAIT_SYNC : S_COPY;
            // NOP and empty RECTs both spend one cycle in PAINT with writes disabled.
            default: begin
              state_d    = S_PAINT;
              paint_en_d = 1'b0;
            end
          endcase
        end
      end
      S_CLEAR: begin
        wr_row = 1'b1;
        if (cy_q == YW'(PX_HEIGHT - 1)) state_d = S_IDLE;
        else                            cy_d    = cy_q + 1'b1;
      end
      S_PAINT: begin
        wr_pix = paint_en_q;
        if (!paint_en_q) begin
          state_d = S_IDLE;
        end else if (({1'b0, cx_q} + 1'b1) == x1_q) begin
          cx_d = x0_q;
          if (({1'b0, cy_q} + 1'b1) == y1_q) state_d = S_IDLE;
          else                               cy_d    = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
      S_WAIT_SYNC: if (vsync_fall) state_d = S_COPY;
      S_COPY: begin
        do_copy = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      x0_q         <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      color_q      <= '0;
      paint_en_q   <= 1'b0;
      back_q       <= '0;
      front_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x0_q         <= x0_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      color_q      <= color_d;
      paint_en_q   <= paint_en_d;
      frame_done_q <= do_copy;
      if (wr_row)  back_q[row_base +: ROWB] <= {PX_WIDTH{color_q}};
      if (wr_pix)  back_q[pix_base +: 3]    <= color_q;
      if (do_copy) front_q                  <= back_q;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign busy       = ~cmd_ready;
  assign frame_done = frame_done_q;
  assign pixel      = {1'b0, front_q};

endmodule
